// File: rtl/motor_link_guard_pkg.sv
// Shared types and constants for the motor link interlock guard.
package MCPkg;

    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

    typedef enum logic [1:0] {
        SAFE    = 2'd0,
        ARMING  = 2'd1,
        ACTIVE  = 2'd2,
        TIMEOUT = 2'd3
    } guard_state_t;

    // Feedback-loop signature the GEFE returns when the serial interlock chain is closed.
    localparam logic [31:0] GEFE_INTERLOCK     = 32'hA55A_C33C;
    localparam logic [31:0] GUARD_SAFE_WORD    = '1;
    localparam int          DEFAULT_TIMEOUT    = 4000;
    localparam int          DEFAULT_ARM_FRAMES = 8;

endpackage

// File: rtl/motor_link_guard_if.sv
// Bundle of the GBT-side stream, motor pin, and status signals of the guard.
interface motor_link_guard_if #(
    parameter int MOTORS    = 16,
    parameter int CTRL_BITS = 4
);
    // frame_valid_i is a one-cycle data-valid strobe with no ready: the rx stream cannot be stalled.
    logic                          frame_valid_i;
    logic [31:0]                   feedback_ib32;
    logic [MOTORS*CTRL_BITS-1:0]   motor_data_ib;
    logic [15:0]                   mem_data_ib16;
    logic [MOTORS-1:0]             enable_mask_ib;
    logic [MOTORS-1:0]             pfail_ib;
    logic                          clear_faults_i;
    logic [MOTORS*CTRL_BITS-1:0]   motor_ctrl_ob;
    logic [15:0]                   mem_data_ob16;
    logic                          mem_valid_o;
    logic [1:0]                    state_ob2;
    logic [MOTORS-1:0]             fault_ob;
    logic [15:0]                   timeout_count_ob16;

    modport master (
        output frame_valid_i, feedback_ib32, motor_data_ib, mem_data_ib16,
               enable_mask_ib, pfail_ib, clear_faults_i,
        input  motor_ctrl_ob, mem_data_ob16, mem_valid_o, state_ob2,
               fault_ob, timeout_count_ob16
    );

    modport slave (
        input  frame_valid_i, feedback_ib32, motor_data_ib, mem_data_ib16,
               enable_mask_ib, pfail_ib, clear_faults_i,
        output motor_ctrl_ob, mem_data_ob16, mem_valid_o, state_ob2,
               fault_ob, timeout_count_ob16
    );

endinterface

// File: rtl/motor_link_guard_watchdog.sv
// Frame-loss watchdog: reloadable down-counter whose expiry strobe fires
// g_timeout enabled cycles after the last load.
module guard_watchdog #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 4000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expired
);
    localparam logic [WIDTH-1:0] RELOAD = WIDTH'(TIMEOUT - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n || load) begin
            count <= RELOAD;
        end else if (enable && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    // Zero means g_timeout-1 idle cycles have already elapsed; the edge seen now is the expiry edge.
    assign expired = enable && !load && (count == '0);

endmodule

// File: rtl/motor_link_guard.sv
// Interlock stage between the GBT rx stream and the stepper-motor pins:
// arming, frame-loss watchdog, per-motor enable masking and latched power-fail faults.
module motor_link_guard
    import MCPkg::*;
#(
    parameter int          g_motors     = 16,
    parameter int          g_ctrl_bits  = 4,
    parameter logic [31:0] g_interlock  = GEFE_INTERLOCK,
    parameter int          g_arm_frames = DEFAULT_ARM_FRAMES,
    parameter int          g_timeout    = DEFAULT_TIMEOUT
) (
    input ckrs_t              ClkRs_ix,
    motor_link_guard_if.slave bus
);
    localparam logic [g_ctrl_bits-1:0] SAFE_CH    = GUARD_SAFE_WORD[g_ctrl_bits-1:0];
    localparam logic [7:0]             ARM_TARGET = 8'(g_arm_frames);

    logic              clk;
    logic              rst_n;
    logic              good;
    logic              bad;
    logic              accept;
    logic              stay_active;
    logic              expired;
    logic              wd_load;
    guard_state_t      state;
    logic [7:0]        arm_cnt;
    logic [15:0]       mem_q;
    logic              mem_valid_q;
    logic [15:0]       tcnt;
    logic [g_motors-1:0] fault;

    assign clk   = ClkRs_ix.clk;
    assign rst_n = ClkRs_ix.reset;

    assign good        = bus.frame_valid_i && (bus.feedback_ib32 == g_interlock);
    assign bad         = bus.frame_valid_i && (bus.feedback_ib32 != g_interlock);
    assign accept      = (state == ACTIVE) && good;
    assign stay_active = (state == ACTIVE) && !bad && !expired;
    assign wd_load     = (state != ACTIVE) || good;

    guard_watchdog #(
        .WIDTH   (16),
        .TIMEOUT (g_timeout)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (rst_n),
        .load    (wd_load),
        .enable  (state == ACTIVE),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= SAFE;
            arm_cnt     <= '0;
            mem_q       <= '0;
            mem_valid_q <= 1'b0;
            tcnt        <= '0;
        end else begin
            mem_valid_q <= accept;
            if (accept) begin
                mem_q <= bus.mem_data_ib16;
            end
            case (state)
                SAFE: begin
                    if (good) begin
                        arm_cnt <= 8'd1;
                        state   <= (ARM_TARGET == 8'd1) ? ACTIVE : ARMING;
                    end
                end
                ARMING: begin
                    if (bad) begin
                        state   <= SAFE;
                        arm_cnt <= '0;
                    end else if (good) begin
                        arm_cnt <= arm_cnt + 8'd1;
                        if (arm_cnt + 8'd1 == ARM_TARGET) begin
                            state <= ACTIVE;
                        end
                    end
                end
                ACTIVE: begin
                    if (bad) begin
                        state   <= SAFE;
                        arm_cnt <= '0;
                    end else if (expired) begin
                        state <= TIMEOUT;
                        if (tcnt != 16'hFFFF) begin
                            tcnt <= tcnt + 16'd1;
                        end
                    end
                end
                TIMEOUT: begin
                    state   <= SAFE;
                    arm_cnt <= '0;
                end
                default: begin
                    state   <= SAFE;
                    arm_cnt <= '0;
                end
            endcase
        end
    end

    // A set on the same cycle as a clear wins, so clearing leaves exactly the still-failing bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault <= '0;
        end else if (bus.clear_faults_i) begin
            fault <= bus.pfail_ib;
        end else begin
            fault <= fault | bus.pfail_ib;
        end
    end

    for (genvar m = 0; m < g_motors; m++) begin : g_chan
        logic                   permitted;
        logic [g_ctrl_bits-1:0] word;

        assign permitted = bus.enable_mask_ib[m] && !fault[m];

        always_ff @(posedge clk) begin
            if (!rst_n || !stay_active || !permitted) begin
                word <= SAFE_CH;
            end else if (good) begin
                word <= bus.motor_data_ib[m*g_ctrl_bits +: g_ctrl_bits];
            end
        end

        assign bus.motor_ctrl_ob[m*g_ctrl_bits +: g_ctrl_bits] = word;
    end

    assign bus.mem_data_ob16      = mem_q;
    assign bus.mem_valid_o        = mem_valid_q;
    assign bus.state_ob2          = state;
    assign bus.fault_ob           = fault;
    assign bus.timeout_count_ob16 = tcnt;

endmodule

// File: tb/tb_motor_link_guard.sv
// Bench for motor_link_guard: directed scenarios plus randomized traffic against a cycle model.
module tb_motor_link_guard;
    import MCPkg::*;

    localparam int          NM  = 16;
    localparam int          CB  = 4;
    localparam int          W   = NM * CB;
    localparam int          T   = 100;
    localparam int          ARM = 8;
    localparam logic [31:0] IL  = GEFE_INTERLOCK;
    localparam logic [W-1:0] ALL_ONES = '1;
    localparam logic [W-1:0] DATA5    = {16{4'b0101}};

    // ---------------- clock / reset ----------------
    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    ckrs_t ckrs;
    assign ckrs.clk   = clk;
    assign ckrs.reset = rst_n;
    always #5 clk = ~clk;

    motor_link_guard_if #(.MOTORS(NM), .CTRL_BITS(CB)) bus();

    motor_link_guard #(
        .g_motors     (NM),
        .g_ctrl_bits  (CB),
        .g_interlock  (IL),
        .g_arm_frames (ARM),
        .g_timeout    (T)
    ) dut (
        .ClkRs_ix (ckrs),
        .bus      (bus)
    );

    // ---------------- reference model ----------------
    int             m_mode;      // 0 SAFE, 1 ARMING, 2 ACTIVE, 3 TIMEOUT
    int             m_arm;
    int             m_elapsed;   // cycles since last good frame while ACTIVE
    logic [CB-1:0]  m_ch [NM];
    logic [15:0]    m_mem;
    logic           m_mv;
    logic [NM-1:0]  m_fault;
    int             m_tcnt;
    logic [15:0]    exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic all_safe();
        for (int m = 0; m < NM; m++) m_ch[m] = '1;
    endtask

    task automatic model_reset();
        m_mode = 0; m_arm = 0; m_elapsed = 0;
        all_safe();
        m_mem = '0; m_mv = 1'b0; m_fault = '0; m_tcnt = 0;
        exp_q.delete();
    endtask

    task automatic model_step();
        logic          good;
        logic          bad;
        logic [NM-1:0] old_fault;
        if (!rst_n) begin
            model_reset();
            return;
        end
        good = bus.frame_valid_i && (bus.feedback_ib32 == IL);
        bad  = bus.frame_valid_i && !good;
        old_fault = m_fault;
        for (int m = 0; m < NM; m++) begin
            if (bus.pfail_ib[m])            m_fault[m] = 1'b1;
            else if (bus.clear_faults_i)    m_fault[m] = 1'b0;
        end
        m_mv = 1'b0;
        case (m_mode)
            0: begin
                all_safe();
                if (good) begin
                    m_arm = 1;
                    m_elapsed = 0;
                    m_mode = (m_arm >= ARM) ? 2 : 1;
                end
            end
            1: begin
                if (bad) begin
                    m_mode = 0; m_arm = 0;
                end else if (good) begin
                    m_arm++;
                    if (m_arm == ARM) begin
                        m_mode = 2; m_elapsed = 0;
                    end
                end
            end
            2: begin
                if (bad) begin
                    m_mode = 0; m_arm = 0; all_safe();
                end else if (good) begin
                    m_elapsed = 0;
                    m_mem = bus.mem_data_ib16;
                    m_mv = 1'b1;
                    exp_q.push_back(m_mem);
                    for (int m = 0; m < NM; m++)
                        m_ch[m] = (bus.enable_mask_ib[m] && !old_fault[m]) ? bus.motor_data_ib[m*CB +: CB] : '1;
                end else if (m_elapsed == T - 1) begin
                    m_mode = 3; m_arm = 0; all_safe();
                    if (m_tcnt < 65535) m_tcnt++;
                end else begin
                    m_elapsed++;
                    for (int m = 0; m < NM; m++)
                        if (!bus.enable_mask_ib[m] || old_fault[m]) m_ch[m] = '1;
                end
            end
            default: begin
                m_mode = 0; m_arm = 0; all_safe();
            end
        endcase
    endtask

    // ---------------- scoreboard ----------------
    task automatic compare_all();
        logic [W-1:0] exp_ctrl;
        logic [15:0]  exp_mem;
        for (int m = 0; m < NM; m++) exp_ctrl[m*CB +: CB] = m_ch[m];
        check("state",         64'(bus.state_ob2),          64'(m_mode));
        check("motor_ctrl",    64'(bus.motor_ctrl_ob),      64'(exp_ctrl));
        check("mem_valid",     64'(bus.mem_valid_o),        64'(m_mv));
        check("fault",         64'(bus.fault_ob),           64'(m_fault));
        check("timeout_count", 64'(bus.timeout_count_ob16), 64'(m_tcnt));
        check("mem_data_hold", 64'(bus.mem_data_ob16),      64'(m_mem));
        if (bus.mem_valid_o === 1'b1) begin
            if (exp_q.size() > 0) begin
                exp_mem = exp_q.pop_front();
                check("mem_stream", 64'(bus.mem_data_ob16), 64'(exp_mem));
            end else begin
                check("mem_unexpected", 64'(bus.mem_valid_o), 64'd0);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic frame(input logic [31:0] fb, input logic [W-1:0] data, input logic [15:0] mem);
        bus.frame_valid_i = 1'b1;
        bus.feedback_ib32 = fb;
        bus.motor_data_ib = data;
        bus.mem_data_ib16 = mem;
        tick();
        bus.frame_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.frame_valid_i = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic arm_link();
        repeat (ARM) frame(IL, '0, 16'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p;
        int len;
        int idx;

        bus.frame_valid_i  = 1'b0;
        bus.feedback_ib32  = '0;
        bus.motor_data_ib  = '0;
        bus.mem_data_ib16  = '0;
        bus.enable_mask_ib = '1;
        bus.pfail_ib       = '0;
        bus.clear_faults_i = 1'b0;

        // Reset and arming
        do_reset();
        check("rst_state", 64'(bus.state_ob2), 64'd0);
        check("rst_ctrl",  64'(bus.motor_ctrl_ob), 64'(ALL_ONES));
        check("rst_mem",   64'(bus.mem_data_ob16), 64'd0);
        check("rst_tcnt",  64'(bus.timeout_count_ob16), 64'd0);
        for (int i = 1; i <= ARM; i++) begin
            frame(IL, '0, 16'h0);
            if (i == ARM - 1) check("arming_state", 64'(bus.state_ob2), 64'd1);
        end
        check("armed_state", 64'(bus.state_ob2), 64'd2);
        check("armed_not_forwarded", 64'(bus.motor_ctrl_ob), 64'(ALL_ONES));
        frame(IL, '0, 16'h0);
        check("first_forward", 64'(bus.motor_ctrl_ob), 64'd0);

        // Pattern break while arming
        do_reset();
        repeat (5) frame(IL, '0, 16'h0);
        frame(32'h0, '0, 16'h0);
        check("break_state", 64'(bus.state_ob2), 64'd0);
        repeat (ARM - 1) frame(IL, '0, 16'h0);
        check("rearm_partial", 64'(bus.state_ob2), 64'd1);
        frame(IL, '0, 16'h0);
        check("rearm_done", 64'(bus.state_ob2), 64'd2);

        // Watchdog
        frame(IL, DATA5, 16'h1111);
        idle(T - 1);
        check("wd_still_active", 64'(bus.state_ob2), 64'd2);
        idle(1);
        check("wd_timeout_state", 64'(bus.state_ob2), 64'd3);
        check("wd_timeout_ctrl",  64'(bus.motor_ctrl_ob), 64'(ALL_ONES));
        check("wd_timeout_count", 64'(bus.timeout_count_ob16), 64'd1);
        idle(1);
        check("wd_back_safe", 64'(bus.state_ob2), 64'd0);

        // Enable mask
        arm_link();
        bus.enable_mask_ib = 16'hFFFE;
        frame(IL, DATA5, 16'h2222);
        check("mask_ch0", 64'(bus.motor_ctrl_ob[3:0]), 64'hF);
        check("mask_ch1", 64'(bus.motor_ctrl_ob[7:4]), 64'h5);
        bus.enable_mask_ib = 16'hFFFC;
        idle(1);
        check("mask_ch1_drop", 64'(bus.motor_ctrl_ob[7:4]), 64'hF);
        bus.enable_mask_ib = '1;

        // Fault latch and clear
        frame(IL, DATA5, 16'h3333);
        bus.pfail_ib = 16'h0008;
        frame(IL, DATA5, 16'h3334);
        bus.pfail_ib = '0;
        check("fault_set", 64'(bus.fault_ob[3]), 64'd1);
        idle(1);
        check("fault_ch3_safe", 64'(bus.motor_ctrl_ob[15:12]), 64'hF);
        bus.pfail_ib = 16'h0008;
        bus.clear_faults_i = 1'b1;
        idle(1);
        bus.clear_faults_i = 1'b0;
        bus.pfail_ib = '0;
        check("fault_clear_blocked", 64'(bus.fault_ob[3]), 64'd1);
        bus.clear_faults_i = 1'b1;
        idle(1);
        bus.clear_faults_i = 1'b0;
        check("fault_cleared", 64'(bus.fault_ob[3]), 64'd0);
        frame(IL, DATA5, 16'h3335);
        check("fault_ch3_driven", 64'(bus.motor_ctrl_ob[15:12]), 64'h5);

        // Memory path
        frame(IL, DATA5, 16'hA5C3);
        check("mem_word",  64'(bus.mem_data_ob16), 64'hA5C3);
        check("mem_pulse", 64'(bus.mem_valid_o), 64'd1);
        idle(1);
        check("mem_pulse_end", 64'(bus.mem_valid_o), 64'd0);
        frame(32'hDEAD_BEEF, DATA5, 16'h1234);
        check("mem_bad_hold",  64'(bus.mem_data_ob16), 64'hA5C3);
        check("mem_bad_novld", 64'(bus.mem_valid_o), 64'd0);
        check("mem_bad_safe",  64'(bus.state_ob2), 64'd0);

        // Randomized traffic in segments of varying frame density
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            case ($urandom_range(0, 3))
                0:       p = 0;
                1:       p = 50;
                default: p = 95;
            endcase
            len = $urandom_range(20, 150);
            for (int c = 0; c < len; c++) begin
                bus.frame_valid_i = ($urandom_range(0, 99) < p);
                bus.feedback_ib32 = ($urandom_range(0, 59) == 0) ? $urandom : IL;
                bus.motor_data_ib = {$urandom, $urandom};
                bus.mem_data_ib16 = 16'($urandom);
                if ($urandom_range(0, 29) == 0) begin
                    idx = $urandom_range(0, NM - 1);
                    bus.enable_mask_ib[idx] = ~bus.enable_mask_ib[idx];
                end
                if ($urandom_range(0, 49) == 0) bus.enable_mask_ib = '1;
                bus.pfail_ib = '0;
                if ($urandom_range(0, 79) == 0) bus.pfail_ib[$urandom_range(0, NM - 1)] = 1'b1;
                bus.clear_faults_i = ($urandom_range(0, 24) == 0);
                rst_n = ($urandom_range(0, 1999) != 0);
                tick();
                rst_n = 1'b1;
            end
        end
        bus.frame_valid_i  = 1'b0;
        bus.pfail_ib       = '0;
        bus.clear_faults_i = 1'b0;
        idle(2);
        check("mem_q_leftover", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
